legv8_multicycle_ctrl: RTL

Main control FSM for the multicycle LEGv8 datapath. It is the producer side of the ALUOp interface. It decodes the 11-bit instruction opcode, sequences each instruction through fetch, decode, execute, memory and writeback states, and drives ALUOp plus all datapath enables. It also handles the memory request/ready handshake and counts retired instructions.

---
 rtl/legv8_ctrl_pkg.sv | 51 +++++
 rtl/legv8_multicycle_ctrl_op_class.sv | 28 ++
 rtl/legv8_multicycle_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the multicycle LEGv8 main control: opcodes, FSM states,
// datapath select encodings and the opcode class bundle.
package legv8_ctrl_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Branch opcodes are matched on their prefix only; the low bits carry immediate.
  localparam logic [7:0] OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0] OP_B_PFX   = 6'b000101;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    R_EXEC,
    R_WB,
    BR_CBZ,
    BR_B
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_PASSB = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  typedef struct packed {
    logic rtype;
    logic ldur;
    logic stur;
    logic cbz;
    logic b;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/legv8_multicycle_ctrl_op_class.sv
// Opcode classifier: maps the 11-bit opcode field to a one-hot instruction class.
module legv8_op_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] op_code,
  output op_class_t   op_class
);

  // Full-opcode matches first, then prefix matches; anything else is illegal.
  always_comb begin
    op_class = '0;
    if ((op_code == OP_ADD) || (op_code == OP_SUB) ||
        (op_code == OP_AND) || (op_code == OP_ORR)) begin
      op_class.rtype = 1'b1;
    end else if (op_code == OP_LDUR) begin
      op_class.ldur = 1'b1;
    end else if (op_code == OP_STUR) begin
      op_class.stur = 1'b1;
    end else if (op_code[10:3] == OP_CBZ_PFX) begin
      op_class.cbz = 1'b1;
    end else if (op_code[10:5] == OP_B_PFX) begin
      op_class.b = 1'b1;
    end else begin
      op_class.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath: sequences each instruction,
// drives ALUOp and datapath enables, handles the memory handshake and counts
// retired instructions.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      op_code,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSource,
  output logic             pc_we,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_class_t        op_class;
  logic             pc_write;
  logic             pc_write_cond;

  legv8_op_class u_op_class (
    .op_code  (op_code),
    .op_class (op_class)
  );

  // State and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and datapath controls decoded from the current state.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    Reg2Loc       = 1'b0;
    RegWrite      = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    ALUOp         = ALUOP_ADD;
    PCSource      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        Reg2Loc = op_class.stur | op_class.cbz;
        if (op_class.rtype)                      state_d = R_EXEC;
        else if (op_class.ldur | op_class.stur)  state_d = MEM_ADDR;
        else if (op_class.cbz)                   state_d = BR_CBZ;
        else if (op_class.b)                     state_d = BR_B;
        else begin
          illegal_op = 1'b1;
          state_d    = FETCH;
        end
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (op_class.ldur)      state_d = MEM_RD;
        else if (op_class.stur) state_d = MEM_WR;
        else                    state_d = FETCH;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        Reg2Loc    = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUOp   = ALUOP_FUNCT;
        state_d = R_WB;
      end
      R_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BR_CBZ: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = SRCB_REG;
        ALUOp         = ALUOP_PASSB;
        Reg2Loc       = 1'b1;
        pc_write_cond = 1'b1;
        PCSource      = 1'b1;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      BR_B: begin
        pc_write   = 1'b1;
        PCSource   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    pc_we = pc_write | (pc_write_cond & zero);

    // Outputs are forced low while reset is held, regardless of the stale state.
    if (reset) begin
      mem_req    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      Reg2Loc    = 1'b0;
      RegWrite   = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = '0;
      ALUOp      = '0;
      PCSource   = 1'b0;
      pc_we      = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
    end

    cnt_d       = cnt_q + (instr_done ? CNT_W'(1) : CNT_W'(0));
    instr_count = reset ? '0 : cnt_q;
  end

endmodule
